// File: rtl/int_controller.sv
// Interrupt controller: edge latch, masking, lowest-index arbitration, EOI handshake.
// Optional INTC_EOI_TIMEOUT_EN: forces IDLE after TIMEOUT unacknowledged SERVICE cycles.
module int_controller #(
   parameter int         N_SRC     = 4,
   parameter logic [7:0] BASE_ADDR = 8'hF8,
   parameter logic [7:0] VEC_RESET = 8'hE0,
   parameter int         TIMEOUT   = 255
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic [7:0]       addr,
   input  logic [7:0]       w_data,
   input  logic             w_en,
   output logic [7:0]       r_data,
   output logic             int_req,
   output logic [7:0]       int_en,
   output logic [7:0]       int_vec
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   localparam logic [8:0] BASE9   = {1'b0, BASE_ADDR};
   localparam logic [7:0] EN_MASK = 8'((9'd1 << (N_SRC + 1)) - 9'd1);

   state_t           state, state_nx;
   logic [N_SRC-1:0] pend, irq_prev, masked, edges, w1c, req_clr;
   logic [2:0]       id, sel;
   logic [7:0]       vec_base;
   logic [1:0]       off;
   logic             hit, wsel, eoi_wr, arb;
   logic             tmo, tmo_hit;

   assign hit    = ({1'b0, addr} >= BASE9) && ({1'b0, addr} < BASE9 + 9'd4);
   assign off    = 2'(addr - BASE_ADDR);
   assign wsel   = w_en && hit;
   assign eoi_wr = wsel && (off == 2'd3);
   assign edges  = irq_src & ~irq_prev;
   assign w1c    = (wsel && off == 2'd1) ? w_data[N_SRC-1:0] : '0;
   assign masked = pend & int_en[N_SRC:1];
   assign arb    = (state == IDLE) && (state_nx == REQ);

   assign int_req = (state == REQ) && int_en[0];
   assign int_vec = vec_base + {3'b000, id, 2'b00};

   always_comb begin
      sel = '0;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (masked[i]) sel = 3'(i);
   end

   always_comb begin
      req_clr = '0;
      if (int_req)
         for (int i = 0; i < N_SRC; i++)
            if (id == 3'(i)) req_clr[i] = 1'b1;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (int_en[0] && |masked) state_nx = REQ;
         REQ:     state_nx = int_en[0] ? SERVICE : IDLE;
         SERVICE: if (eoi_wr || tmo_hit) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         int_en   <= '0;
         pend     <= '0;
         irq_prev <= '0;
         vec_base <= VEC_RESET;
         id       <= '0;
      end else begin
         state    <= state_nx;
         irq_prev <= irq_src;
         // a fresh edge outranks both W1C and the REQ-cycle clear
         pend     <= (pend & ~w1c & ~req_clr) | edges;
         if (wsel && off == 2'd0) int_en <= w_data & EN_MASK;
         if (wsel && off == 2'd2) vec_base <= w_data;
         if (arb) id <= sel;
      end
   end

`ifdef INTC_EOI_TIMEOUT_EN
   logic [7:0] cnt;

   assign tmo_hit = (state == SERVICE) && (cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
         tmo <= 1'b0;
      end else begin
         cnt <= (state == SERVICE && !tmo_hit) ? cnt + 8'd1 : 8'd0;
         if (eoi_wr)       tmo <= 1'b0;
         else if (tmo_hit) tmo <= 1'b1;
      end
   end
`else
   logic unused_tmo;

   assign tmo_hit    = 1'b0;
   assign tmo        = 1'b0;
   assign unused_tmo = ^8'(TIMEOUT);
`endif

   always_comb begin
      r_data = '0;
      if (hit) begin
         unique case (off)
            2'd0: r_data = int_en;
            2'd1: r_data = 8'(pend);
            2'd2: r_data = vec_base;
            2'd3: r_data = {state == SERVICE, tmo, 3'b000, id};
         endcase
      end
   end

endmodule
